// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the in-order ALU issue queue: ALU type encoding and entry control record.
package alu_issue_queue_pkg;

  localparam int ALU_TYPE_W = 10;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SLT  = 1;
  localparam int ALU_SLTU = 2;
  localparam int ALU_XOR  = 3;
  localparam int ALU_OR   = 4;
  localparam int ALU_AND  = 5;
  localparam int ALU_SLL  = 6;
  localparam int ALU_SRL  = 7;
  localparam int ALU_SRA  = 8;
  localparam int ALU_SUB  = 9;

  typedef logic [ALU_TYPE_W-1:0] alu_type_t;

  // Operand state lives in the wakeup sub-modules; this is the per-slot control part.
  typedef struct packed {
    logic      valid;
    alu_type_t alu_type;
  } iq_entry_t;

endpackage

// File: rtl/alu_iq_wakeup.sv
// One operand slot of an issue-queue entry: holds tag/data/ready and captures writeback broadcasts,
// including a broadcast that lands in the same cycle the operand is written.
module alu_iq_wakeup #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              entry_valid,
  input  logic              wr_en,
  input  logic              clr_en,
  input  logic              wr_rdy,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rdy,
  output logic [DATA_W-1:0] data
);

  logic              rdy_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] data_r;
  logic              hit_enq_s;
  logic              hit_wait_s;

  // Tag match for the operand being written and for an already-waiting operand.
  always_comb begin
    hit_enq_s  = wb_valid && (wb_tag == wr_tag);
    hit_wait_s = entry_valid && !rdy_r && wb_valid && (wb_tag == tag_r);
  end

  // Ready bit: reset/flush clear it, write loads it, wakeup sets it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_r <= 1'b0;
    end else if (flush) begin
      rdy_r <= 1'b0;
    end else if (wr_en) begin
      rdy_r <= wr_rdy || hit_enq_s;
    end else if (clr_en) begin
      rdy_r <= 1'b0;
    end else if (hit_wait_s) begin
      rdy_r <= 1'b1;
    end else begin
      rdy_r <= rdy_r;
    end
  end

  // Tag and value storage; contents are only meaningful while rdy_r/entry_valid say so.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_r  <= wr_tag;
      data_r <= wr_rdy ? wr_data : wb_data;
    end else if (hit_wait_s) begin
      data_r <= wb_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign rdy  = rdy_r;
  assign data = data_r;

endmodule

// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue with operand wakeup from a writeback broadcast.
// Optional performance counters are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [ALU_TYPE_W-1:0] enq_alu_type,
  input  logic [DATA_W-1:0]     enq_src1,
  input  logic [DATA_W-1:0]     enq_src2,
  input  logic                  enq_src1_rdy,
  input  logic                  enq_src2_rdy,
  input  logic [TAG_W-1:0]      enq_ps1,
  input  logic [TAG_W-1:0]      enq_ps2,
  input  logic [TAG_W-1:0]      enq_prd,
  input  logic                  wb_valid,
  input  logic [TAG_W-1:0]      wb_tag,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  iss_valid,
  input  logic                  iss_ready,
  output logic [DATA_W-1:0]     iss_src1,
  output logic [DATA_W-1:0]     iss_src2,
  output logic [ALU_TYPE_W-1:0] iss_alu_type,
  output logic [TAG_W-1:0]      iss_prd
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_full_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  iq_entry_t         entry_r [DEPTH];
  logic [TAG_W-1:0]  prd_r   [DEPTH];

  logic              rdy1_s  [DEPTH];
  logic              rdy2_s  [DEPTH];
  logic [DATA_W-1:0] data1_s [DEPTH];
  logic [DATA_W-1:0] data2_s [DEPTH];
  logic [DEPTH-1:0]  wr_en_s;
  logic [DEPTH-1:0]  clr_en_s;
  logic [DEPTH-1:0]  valid_s;
  logic              enq_ready_s;
  logic              iss_valid_s;
  logic              enq_fire_s;
  logic              deq_fire_s;

  // Handshake decode; flush suppresses both transfers so it wins over them.
  always_comb begin
    enq_ready_s = (count_r != CNT_W'(DEPTH));
    iss_valid_s = (count_r != {CNT_W{1'b0}}) && rdy1_s[head_r] && rdy2_s[head_r];
    enq_fire_s  = enq_valid && enq_ready_s && !flush;
    deq_fire_s  = iss_valid_s && iss_ready && !flush;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en_s[i]  = enq_fire_s && (tail_r == PTR_W'(i));
      clr_en_s[i] = deq_fire_s && (head_r == PTR_W'(i));
      valid_s[i]  = entry_r[i].valid;
    end
  end

  // Head/tail/count bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (enq_fire_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (deq_fire_s) begin
        head_r <= head_r + PTR_W'(1);
      end else begin
        head_r <= head_r;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry valid flags and ALU type.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '{valid: 1'b0, alu_type: {ALU_TYPE_W{1'b0}}};
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_s[i]) begin
          entry_r[i].valid    <= 1'b1;
          entry_r[i].alu_type <= enq_alu_type;
        end else if (clr_en_s[i]) begin
          entry_r[i].valid <= 1'b0;
        end else begin
          entry_r[i] <= entry_r[i];
        end
      end
    end
  end

  // Destination tag storage.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en_s[i]) begin
        prd_r[i] <= enq_prd;
      end else begin
        prd_r[i] <= prd_r[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    alu_iq_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src1 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .entry_valid(valid_s[g]), .wr_en(wr_en_s[g]), .clr_en(clr_en_s[g]),
      .wr_rdy(enq_src1_rdy), .wr_tag(enq_ps1), .wr_data(enq_src1),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .rdy(rdy1_s[g]), .data(data1_s[g])
    );
    alu_iq_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src2 (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .entry_valid(valid_s[g]), .wr_en(wr_en_s[g]), .clr_en(clr_en_s[g]),
      .wr_rdy(enq_src2_rdy), .wr_tag(enq_ps2), .wr_data(enq_src2),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .rdy(rdy2_s[g]), .data(data2_s[g])
    );
  end

  // Issue payload is zeroed whenever nothing is being offered.
  always_comb begin
    enq_ready = enq_ready_s;
    iss_valid = iss_valid_s;
    if (iss_valid_s) begin
      iss_src1     = data1_s[head_r];
      iss_src2     = data2_s[head_r];
      iss_alu_type = entry_r[head_r].alu_type;
      iss_prd      = prd_r[head_r];
    end else begin
      iss_src1     = {DATA_W{1'b0}};
      iss_src2     = {DATA_W{1'b0}};
      iss_alu_type = {ALU_TYPE_W{1'b0}};
      iss_prd      = {TAG_W{1'b0}};
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] full_cnt_r;

  // Saturating event counters; deliberately not cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 32'd0;
      full_cnt_r  <= 32'd0;
    end else begin
      if ((count_r != {CNT_W{1'b0}}) && !iss_valid_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (enq_valid && !enq_ready_s && (full_cnt_r != 32'hFFFF_FFFF)) begin
        full_cnt_r <= full_cnt_r + 32'd1;
      end else begin
        full_cnt_r <= full_cnt_r;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_full_cnt  = full_cnt_r;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed scoreboard bench for alu_issue_queue (DEPTH=4, DATA_W=64, TAG_W=6).
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n, flush, enq_valid, enq_ready;
  logic [9:0]  enq_alu_type;
  logic [63:0] enq_src1, enq_src2;
  logic        enq_src1_rdy, enq_src2_rdy;
  logic [5:0]  enq_ps1, enq_ps2, enq_prd;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [63:0] wb_data;
  logic        iss_valid, iss_ready;
  logic [63:0] iss_src1, iss_src2;
  logic [9:0]  iss_alu_type;
  logic [5:0]  iss_prd;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_full_cnt;
`endif

  alu_issue_queue #(.DEPTH(4), .DATA_W(64), .TAG_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_alu_type(enq_alu_type),
    .enq_src1(enq_src1), .enq_src2(enq_src2),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .enq_ps1(enq_ps1), .enq_ps2(enq_ps2), .enq_prd(enq_prd),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_alu_type(iss_alu_type), .iss_prd(iss_prd)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] s1;
    logic [63:0] s2;
    logic [9:0]  ty;
    logic [5:0]  prd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] oh(input int idx);
    logic [9:0] v;
    v = 10'b1;
    return v << idx;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] s1, input logic [63:0] s2, input logic [9:0] ty,
                      input logic [5:0] prd);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.ty = ty; e.prd = prd;
    sb.push_back(e);
  endtask

  task automatic drive_enq(input logic [9:0] ty, input logic [63:0] s1, input logic r1,
                           input logic [5:0] ps1, input logic [63:0] s2, input logic r2,
                           input logic [5:0] ps2, input logic [5:0] prd);
    enq_valid = 1'b1; enq_alu_type = ty;
    enq_src1 = s1; enq_src1_rdy = r1; enq_ps1 = ps1;
    enq_src2 = s2; enq_src2_rdy = r2; enq_ps2 = ps2;
    enq_prd = prd;
  endtask

  task automatic enq(input logic [9:0] ty, input logic [63:0] s1, input logic r1,
                     input logic [5:0] ps1, input logic [63:0] s2, input logic r2,
                     input logic [5:0] ps2, input logic [5:0] prd);
    drive_enq(ty, s1, r1, ps1, s2, r2, ps2, prd);
    step();
    enq_valid = 1'b0;
  endtask

  // Issue monitor: every accepted issue must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("iss_src1", iss_src1, mon_e.s1);
        chk("iss_src2", iss_src2, mon_e.s2);
        chk("iss_alu_type", 64'(iss_alu_type), 64'(mon_e.ty));
        chk("iss_prd", 64'(iss_prd), 64'(mon_e.prd));
      end
    end
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_alu_type = 10'd0;
    enq_src1 = 64'd0; enq_src2 = 64'd0; enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0;
    enq_ps1 = 6'd0; enq_ps2 = 6'd0; enq_prd = 6'd0;
    wb_valid = 1'b0; wb_tag = 6'd0; wb_data = 64'd0; iss_ready = 1'b0;
    #12;
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_src1", iss_src1, 64'd0);
    reset_n = 1'b1;
    step();

    // ADD with both operands ready issues the next cycle
    iss_ready = 1'b1;
    push(64'd5, 64'd7, oh(ALU_ADD), 6'd1);
    enq(oh(ALU_ADD), 64'd5, 1'b1, 6'd0, 64'd7, 1'b1, 6'd0, 6'd1);
    chk("add_iss_valid", 64'(iss_valid), 64'd1);
    step();
    chk("add_empty_after", 64'(iss_valid), 64'd0);
    chk("add_zero_payload", iss_src1, 64'd0);

    // SUB waits on tag 9; no same-cycle bypass of the wakeup
    push(64'd10, 64'd3, oh(ALU_SUB), 6'd2);
    enq(oh(ALU_SUB), 64'd10, 1'b1, 6'd0, 64'd99, 1'b0, 6'd9, 6'd2);
    wb_valid = 1'b1; wb_tag = 6'd9; wb_data = 64'd3;
    #1;
    chk("sub_no_bypass", 64'(iss_valid), 64'd0);
    step();
    wb_valid = 1'b0;
    chk("sub_wake_valid", 64'(iss_valid), 64'd1);
    step();

    // SLL captures a wakeup arriving in the enqueue cycle
    push(64'h10, 64'd2, oh(ALU_SLL), 6'd3);
    drive_enq(oh(ALU_SLL), 64'hdead, 1'b0, 6'd4, 64'd2, 1'b1, 6'd0, 6'd3);
    wb_valid = 1'b1; wb_tag = 6'd4; wb_data = 64'h10;
    step();
    enq_valid = 1'b0; wb_valid = 1'b0;
    chk("sll_same_cycle_valid", 64'(iss_valid), 64'd1);
    step();

    // Fill to full with issue blocked, then drain; pointers wrap from slot 3
    iss_ready = 1'b0;
    push(64'h100, 64'd1, oh(ALU_ADD), 6'd10);
    enq(oh(ALU_ADD), 64'h100, 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 6'd10);
    push(64'h200, 64'd2, oh(ALU_XOR), 6'd11);
    enq(oh(ALU_XOR), 64'h200, 1'b1, 6'd0, 64'd2, 1'b1, 6'd0, 6'd11);
    push(64'h300, 64'd3, 10'b0000000011, 6'd12);
    enq(10'b0000000011, 64'h300, 1'b1, 6'd0, 64'd3, 1'b1, 6'd0, 6'd12);
    push(64'h400, 64'd4, oh(ALU_SRA), 6'd13);
    enq(oh(ALU_SRA), 64'h400, 1'b1, 6'd0, 64'd4, 1'b1, 6'd0, 6'd13);
    push(64'h500, 64'd5, oh(ALU_OR), 6'd14);
    drive_enq(oh(ALU_OR), 64'h500, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 6'd14);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    chk("full_iss_valid", 64'(iss_valid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("full_hold_src1", iss_src1, 64'h100);
      chk("full_hold_prd", 64'(iss_prd), 64'd10);
      chk("full_hold_ready", 64'(enq_ready), 64'd0);
    end
    iss_ready = 1'b1;
    step();
    chk("deq_while_full_no_enq", 64'(enq_ready), 64'd1);
    chk("drain_second_src1", iss_src1, 64'h200);
    step();
    enq_valid = 1'b0;
    chk("enq_deq_same_cycle_ready", 64'(enq_ready), 64'd1);
    chk("enq_deq_third_src1", iss_src1, 64'h300);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_iss_valid", 64'(iss_valid), 64'd0);

    // Non-ready head blocks a younger ready entry
    push(64'h22, 64'h5, oh(ALU_ADD), 6'd20);
    enq(oh(ALU_ADD), 64'h0, 1'b0, 6'd2, 64'h5, 1'b1, 6'd0, 6'd20);
    push(64'h33, 64'h44, oh(ALU_AND), 6'd21);
    enq(oh(ALU_AND), 64'h33, 1'b1, 6'd0, 64'h44, 1'b1, 6'd0, 6'd21);
    for (int i = 0; i < 3; i++) begin
      chk("blocked_head", 64'(iss_valid), 64'd0);
      step();
    end
    wb_valid = 1'b1; wb_tag = 6'd2; wb_data = 64'h22;
    step();
    wb_valid = 1'b0;
    chk("unblock_prd", 64'(iss_prd), 64'd20);
    step();
    chk("younger_prd", 64'(iss_prd), 64'd21);
    step();
    chk("blocked_drained", 64'(iss_valid), 64'd0);

    // Flush beats a simultaneous enqueue
    iss_ready = 1'b0;
    enq(oh(ALU_SLT), 64'd1, 1'b1, 6'd0, 64'd2, 1'b1, 6'd0, 6'd30);
    chk("pre_flush_valid", 64'(iss_valid), 64'd1);
    drive_enq(oh(ALU_XOR), 64'd8, 1'b1, 6'd0, 64'd9, 1'b1, 6'd0, 6'd33);
    flush = 1'b1;
    step();
    flush = 1'b0; enq_valid = 1'b0;
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    chk("flush_enq_ready", 64'(enq_ready), 64'd1);
    step();
    chk("flush_enq_dropped", 64'(iss_valid), 64'd0);
    iss_ready = 1'b1;
    push(64'h77, 64'h3, oh(ALU_SRL), 6'd31);
    enq(oh(ALU_SRL), 64'h77, 1'b1, 6'd0, 64'h3, 1'b1, 6'd0, 6'd31);
    chk("post_flush_valid", 64'(iss_valid), 64'd1);
    step();
    chk("post_flush_empty", 64'(iss_valid), 64'd0);

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_full_cnt", 64'(perf_full_cnt), 64'd3);
    chk("perf_stall_nonzero", 64'(perf_stall_cnt != 32'd0), 64'd1);
`endif

    // Asynchronous reset mid-cycle with three entries queued
    iss_ready = 1'b0;
    enq(oh(ALU_ADD), 64'd1, 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 6'd35);
    enq(oh(ALU_OR), 64'd2, 1'b1, 6'd0, 64'd2, 1'b1, 6'd0, 6'd36);
    enq(oh(ALU_AND), 64'd3, 1'b1, 6'd0, 64'd3, 1'b1, 6'd0, 6'd37);
    chk("pre_reset_valid", 64'(iss_valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("async_rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("async_rst_src1", iss_src1, 64'd0);
    chk("async_rst_prd", 64'(iss_prd), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("async_rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
    chk("async_rst_perf_full", 64'(perf_full_cnt), 64'd0);
`endif
    #10;
    reset_n = 1'b1;
    step();
    chk("post_reset_empty", 64'(iss_valid), 64'd0);
    iss_ready = 1'b1;
    push(64'd9, 64'd8, oh(ALU_SLTU), 6'd40);
    enq(oh(ALU_SLTU), 64'd9, 1'b1, 6'd0, 64'd8, 1'b1, 6'd0, 6'd40);
    step();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 64, operand and result width.
REQ-003 SHALL have parameter TAG_W, default 6, physical destination/source tag width.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush  in  1  synchronous kill of all entries.
REQ-007 SHALL have port enq_valid  in  1  micro-op offered for enqueue.
REQ-008 SHALL have port enq_ready  out  1  queue can accept; high when count < DEPTH.
REQ-009 SHALL have port enq_alu_type  in  10  one-hot: 0 ADD, 1 SLT, 2 SLTU, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA, 9 SUB.
REQ-010 SHALL have ports enq_src1/enq_src2  in  DATA_W each  operand values, meaningful only when the matching rdy bit is set.
REQ-011 SHALL have ports enq_src1_rdy/enq_src2_rdy  in  1 each  operand already available.
REQ-012 SHALL have ports enq_ps1/enq_ps2  in  TAG_W each  source tags awaited when not ready.
REQ-013 SHALL have port enq_prd  in  TAG_W  destination tag.
REQ-014 SHALL have ports wb_valid  in  1, wb_tag  in  TAG_W, wb_data  in  DATA_W  writeback wakeup broadcast.
REQ-015 SHALL have ports iss_valid  out  1, iss_ready  in  1  issue handshake toward ALU stage.
REQ-016 SHALL have ports iss_src1/iss_src2  out  DATA_W, iss_alu_type  out  10, iss_prd  out  TAG_W  issued micro-op payload.

Function
REQ-017 SHALL store entries in FIFO order with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH and a count of log2(DEPTH)+1 bits.
REQ-018 SHALL enqueue on the clock edge where enq_valid and enq_ready are both high, writing the entry at tail.
REQ-019 SHALL, on any cycle with wb_valid high, set rdy and capture wb_data for every valid entry operand whose tag equals wb_tag and whose rdy is clear.
REQ-020 SHALL, when an enqueue coincides with a wakeup matching an enqueued not-ready operand, store that operand ready with wb_data (same-cycle capture).
REQ-021 SHALL drive iss_valid high combinationally iff the queue is non-empty and both head operands are ready; no bypass of wb_data to iss_src outputs in the same cycle.
REQ-022 SHALL dequeue the head on the edge where iss_valid and iss_ready are both high; payload held stable while iss_valid high and iss_ready low.
REQ-023 SHALL issue strictly in order; a non-ready head blocks younger ready entries.
REQ-024 SHALL allow enqueue and dequeue in the same cycle, count unchanged; when full, enq_ready stays low even if a dequeue occurs that cycle.
REQ-025 SHALL, on flush, empty the queue (head=tail=0, count=0) at the edge; flush overrides a simultaneous enqueue, dequeue and wakeup.
REQ-026 SHALL pass iss_alu_type exactly as enqueued; an entry with non-one-hot alu_type is still issued unchanged.
REQ-027 SHALL force iss_src1, iss_src2, iss_alu_type, iss_prd to zero when iss_valid is low.

Reset
REQ-028 SHALL, on reset_n low, immediately clear head, tail, count and all entry valid/rdy bits, regardless of clock.
REQ-029 SHALL drive enq_ready=1 and iss_valid=0 with all payload outputs zero while in reset; entry data storage need not be reset.

Configuration
REQ-030 SHALL, with ALU_ISSUE_PERF_EN defined, provide outputs perf_stall_cnt (32) counting cycles with non-empty queue and iss_valid low, and perf_full_cnt (32) counting cycles with enq_valid high and enq_ready low; both saturate at all-ones, reset to 0, unaffected by flush.
REQ-031 SHALL, without ALU_ISSUE_PERF_EN, omit both ports and counters entirely.

Structure
REQ-032 SHALL place the ALU_TYPE one-hot bit-index constants, the 10-bit ALU type width, and the queue entry struct typedef in the shared defines package.
REQ-033 SHALL implement per-entry operand wakeup compare/capture in one sub-module, alu_iq_wakeup, instantiated twice per entry.

Verification
REQ-034 SHALL cover: enqueue ADD src1=5 src2=7 both ready, iss_ready=1 -> iss_valid next cycle, iss_src1=5, iss_src2=7, iss_alu_type=10'b1, queue empty after.
REQ-035 SHALL cover: enqueue SUB with ps2=9 not ready, then wb_valid tag=9 data=3 -> iss_valid rises the cycle after wakeup with iss_src2=3.
REQ-036 SHALL cover: enqueue SLL with ps1=4 not ready while wb tag=4 data=0x10 in the same cycle -> entry issues next cycle with iss_src1=0x10.
REQ-037 SHALL cover: fill 4 entries with iss_ready=0 -> enq_ready=0, payload stable; iss_ready=1 drains in order with pointers wrapping correctly.
REQ-038 SHALL cover: head waiting on tag 2, younger entry ready -> no issue until tag 2 wakeup; flush asserted with enq_valid -> queue empty, enqueue dropped.
REQ-039 SHALL cover: reset_n pulsed low mid-clock with 3 entries -> iss_valid=0 and enq_ready=1 immediately; perf counters 0 when ALU_ISSUE_PERF_EN defined.
